branch_predictor_gshare: RTL and testbench
==========================================

Name: branch_predictor_gshare

Overview:
- Parametrised direction predictor serving the decode/issue stage. Replaces the fixed "always taken" branch guess.
- Holds a table of saturating counters indexed by PC, optionally XOR-folded with a global history register (GHR).
- Decode queries it combinationally. ROB commit trains it. A ROB flush restores speculative history.
- The decoder carries pred_idx through the ROB, so training hits the same entry that produced the prediction.

Parameters:
- BHT_SIZE_BIT, 8, log2 of counter-table entries (256).
- CNT_BITS, 2, width of each saturating counter (≥1).
- GHR_BITS, 6, global history length (1..BHT_SIZE_BIT); ignored when MODE=0.
- MODE, 1, 0 = bimodal (PC only); 1 = gshare (PC XOR GHR).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  global ready; all state frozen when low
- qry_valid  input  1  decoder is issuing a conditional branch this cycle (not stalled)
- qry_pc  input  32  address of that branch
- pred_taken  output  1  prediction for qry_pc (combinational)
- pred_idx  output  BHT_SIZE_BIT  table index used for pred_taken (combinational)
- upd_valid  input  1  ROB commits a conditional branch this cycle
- upd_idx  input  BHT_SIZE_BIT  pred_idx captured at decode for that branch
- upd_taken  input  1  resolved direction
- upd_mispred  input  1  resolved direction differed from prediction
- rob_clear  input  1  pipeline flush (same cycle-level signal the ROB drives to decode)
- miss_cnt  output  32  number of committed mispredictions, saturating at 0xFFFFFFFF

Behaviour:
Index and prediction (combinational)
- MODE=0: pred_idx = qry_pc[BHT_SIZE_BIT+1:2].
- MODE=1: pred_idx = qry_pc[BHT_SIZE_BIT+1:2] XOR {zeros, spec_ghr}. GHR is zero-extended at the MSB side.
- pred_taken = MSB of counter[pred_idx]. The output is valid regardless of qry_valid and rdy_in.

Reset (async, rst_in high)
- Every counter is set to 2^(CNT_BITS-1) (weakly taken). Power-on behaviour therefore matches the old always-taken scheme.
- spec_ghr = 0, commit_ghr = 0, miss_cnt = 0.
- Reset mid-operation discards any training in flight. No partial update of any state is permitted.

Sequential, posedge clk_in, only when rdy_in=1 and rst_in=0
- Training, when upd_valid=1:
  - upd_taken=1: counter[upd_idx] += 1, saturating at 2^CNT_BITS-1.
  - upd_taken=0: counter[upd_idx] -= 1, saturating at 0.
  - commit_ghr <= {commit_ghr[GHR_BITS-2:0], upd_taken}.
  - miss_cnt increments if upd_mispred=1 and miss_cnt is not already all ones.
- Speculative history, when qry_valid=1 and rob_clear=0:
  - spec_ghr <= {spec_ghr[GHR_BITS-2:0], pred_taken}.
- Flush, when rob_clear=1:
  - spec_ghr <= commit_ghr as updated this cycle, i.e. including the shift from a simultaneous upd_valid.
  - qry_valid is ignored in that cycle.
- With rdy_in=0, no state changes. Outputs still reflect the current state.

Simultaneous events
- Query and update to the same index in one cycle: pred_taken uses the pre-update counter. The new value is visible from the next cycle.
- upd_valid together with rob_clear: both apply. Training happens, then the restore uses the freshly shifted commit_ghr.
- MODE=0: GHR registers may be optimised away but must not affect pred_idx.

Latency
- Prediction: 0 cycles.
- Training: visible 1 cycle after upd_valid.
- Flush restore: visible 1 cycle after rob_clear.

Test Plan:
- Reset, MODE=0: query pc=0x100 → pred_taken=1, pred_idx=0x40, miss_cnt=0.
- Saturation at zero, MODE=0, CNT_BITS=2: three updates, idx=0x40, taken=0 → pred_taken=0 from the 2nd update on, counter stays 0. Then one taken update → counter=1, pred_taken still 0.
- Saturation at top, MODE=0, CNT_BITS=2: four taken updates, idx=5 → counter=3, no wrap to 0. pred_taken stays 1.
- GHR shift, MODE=1, GHR_BITS=6: 3 queries at pc=0x0 with predictions 1,1,1 → spec_ghr=0b000111, pred_idx for pc=0x0 = 0x07.
- Flush restore with simultaneous commit: same setup, then rob_clear together with upd_valid, upd_taken=0 while commit_ghr=0 → next cycle spec_ghr=0, commit_ghr=0. A qry_valid asserted in the flush cycle has no effect.
- Freeze and miss counter: rdy_in=0 with upd_valid=1, upd_mispred=1 → counters and miss_cnt unchanged. Same stimulus with rdy_in=1 → miss_cnt=1. Forcing miss_cnt=0xFFFFFFFF then mispredicting → it stays 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_predictor_gshare_if.sv
// Predictor bus between decode/ROB and the direction predictor.
//   rdy_in                       : global ready, freezes predictor state when low
//   qry_valid, qry_pc            : decode-side branch query
//   pred_taken, pred_idx         : combinational prediction and the table index it used
//   upd_valid, upd_idx,
//   upd_taken, upd_mispred       : ROB commit-side training
//   rob_clear                    : pipeline flush, restores speculative history
//   miss_cnt                     : saturating count of committed mispredictions
// master = pipeline side, slave = predictor side.
interface branch_predictor_gshare_if #(
  parameter int unsigned BHT_SIZE_BIT = 8
);
  logic                    rdy_in;
  logic                    qry_valid;
  logic [31:0]             qry_pc;
  logic                    pred_taken;
  logic [BHT_SIZE_BIT-1:0] pred_idx;
  logic                    upd_valid;
  logic [BHT_SIZE_BIT-1:0] upd_idx;
  logic                    upd_taken;
  logic                    upd_mispred;
  logic                    rob_clear;
  logic [31:0]             miss_cnt;

  modport master (
    output rdy_in, qry_valid, qry_pc, upd_valid, upd_idx, upd_taken, upd_mispred, rob_clear,
    input  pred_taken, pred_idx, miss_cnt
  );

  modport slave (
    input  rdy_in, qry_valid, qry_pc, upd_valid, upd_idx, upd_taken, upd_mispred, rob_clear,
    output pred_taken, pred_idx, miss_cnt
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Branch direction predictor: table of saturating counters indexed by PC,
// optionally XOR-folded with a speculative global history register (gshare).
//   clk_in : system clock
//   rst_in : asynchronous active-high reset
//   bp     : predictor bus (slave side), see branch_predictor_gshare_if
// Prediction and index are combinational; training, history and the miss
// counter are registered and only advance while bp.rdy_in is high.
module branch_predictor_gshare #(
  parameter int unsigned BHT_SIZE_BIT = 8,
  parameter int unsigned CNT_BITS     = 2,
  parameter int unsigned GHR_BITS     = 6,
  parameter int unsigned MODE         = 1
) (
  input logic                      clk_in,
  input logic                      rst_in,
  branch_predictor_gshare_if.slave bp
);

  localparam int unsigned BHT_SIZE = 1 << BHT_SIZE_BIT;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  // Weakly taken, so an untrained table behaves like the old always-taken guess.
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'(1) << (CNT_BITS - 1);

  logic [CNT_BITS-1:0]     cnt_q [BHT_SIZE];
  logic [GHR_BITS-1:0]     spec_ghr_q;
  logic [GHR_BITS-1:0]     spec_ghr_d;
  logic [GHR_BITS-1:0]     commit_ghr_q;
  logic [GHR_BITS-1:0]     commit_ghr_d;
  logic [31:0]             miss_cnt_q;
  logic [31:0]             miss_cnt_d;
  logic [CNT_BITS-1:0]     cnt_upd;
  logic [CNT_BITS-1:0]     pred_cnt;
  logic [BHT_SIZE_BIT-1:0] pc_idx;
  logic [BHT_SIZE_BIT-1:0] pred_idx;
  logic                    pred_taken;
  logic                    unused_pc;

  // Word-aligned PC bits select the entry; the rest of the PC does not matter.
  assign pc_idx    = bp.qry_pc[BHT_SIZE_BIT+1:2];
  assign unused_pc = ^{bp.qry_pc[31:BHT_SIZE_BIT+2], bp.qry_pc[1:0]};

  // Index selection: history is zero-extended at the MSB side before the XOR.
  generate
    if (MODE != 0) begin : g_gshare
      assign pred_idx = pc_idx ^ BHT_SIZE_BIT'(spec_ghr_q);
    end else begin : g_bimodal
      logic unused_ghr;
      assign pred_idx   = pc_idx;
      assign unused_ghr = ^spec_ghr_q;
    end
  endgenerate

  // Prediction is the counter MSB, read before any same-cycle training.
  assign pred_cnt      = cnt_q[pred_idx];
  assign pred_taken    = pred_cnt[CNT_BITS-1];
  assign bp.pred_taken = pred_taken;
  assign bp.pred_idx   = pred_idx;
  assign bp.miss_cnt   = miss_cnt_q;

  // Next-state: saturating training, commit/speculative history, miss counter.
  always_comb begin
    cnt_upd      = cnt_q[bp.upd_idx];
    commit_ghr_d = commit_ghr_q;
    spec_ghr_d   = spec_ghr_q;
    miss_cnt_d   = miss_cnt_q;

    if (bp.upd_valid) begin
      if (bp.upd_taken) begin
        if (cnt_upd != CNT_MAX) begin
          cnt_upd = cnt_upd + CNT_BITS'(1);
        end
      end else if (cnt_upd != '0) begin
        cnt_upd = cnt_upd - CNT_BITS'(1);
      end
      // Truncating cast drops the oldest bit and also covers GHR_BITS == 1.
      commit_ghr_d = GHR_BITS'({commit_ghr_q, bp.upd_taken});
      if (bp.upd_mispred && (miss_cnt_q != '1)) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end

    // A flush wins over a query and restores the history including this cycle's commit.
    if (bp.rob_clear) begin
      spec_ghr_d = commit_ghr_d;
    end else if (bp.qry_valid) begin
      spec_ghr_d = GHR_BITS'({spec_ghr_q, pred_taken});
    end
  end

  // Counter table.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(BHT_SIZE); i++) begin
        cnt_q[i] <= CNT_INIT;
      end
    end else if (bp.rdy_in && bp.upd_valid) begin
      cnt_q[bp.upd_idx] <= cnt_upd;
    end
  end

  // History registers and miss counter.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      spec_ghr_q   <= '0;
      commit_ghr_q <= '0;
      miss_cnt_q   <= '0;
    end else if (bp.rdy_in) begin
      spec_ghr_q   <= spec_ghr_d;
      commit_ghr_q <= commit_ghr_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Self-checking bench: one bimodal (MODE=0) and one gshare (MODE=1) instance.
// Expected outputs are queued when stimulus is driven and compared on sampling.
module tb_branch_predictor_gshare;

  localparam int unsigned BHT_SIZE_BIT = 8;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  branch_predictor_gshare_if #(.BHT_SIZE_BIT(BHT_SIZE_BIT)) bus_b ();
  branch_predictor_gshare_if #(.BHT_SIZE_BIT(BHT_SIZE_BIT)) bus_g ();

  branch_predictor_gshare #(
    .BHT_SIZE_BIT(BHT_SIZE_BIT), .CNT_BITS(2), .GHR_BITS(6), .MODE(0)
  ) u_bim (
    .clk_in(clk_in), .rst_in(rst_in), .bp(bus_b)
  );

  branch_predictor_gshare #(
    .BHT_SIZE_BIT(BHT_SIZE_BIT), .CNT_BITS(2), .GHR_BITS(6), .MODE(1)
  ) u_gsh (
    .clk_in(clk_in), .rst_in(rst_in), .bp(bus_g)
  );

  typedef enum int { K_BT, K_BI, K_BM, K_GT, K_GI, K_GM } kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_BT:    return 32'(bus_b.pred_taken);
      K_BI:    return 32'(bus_b.pred_idx);
      K_BM:    return bus_b.miss_cnt;
      K_GT:    return 32'(bus_g.pred_taken);
      K_GI:    return 32'(bus_g.pred_idx);
      default: return bus_g.miss_cnt;
    endcase
  endfunction

  task automatic expect_out(input string name, input kind_e k, input logic [31:0] v);
    sb.push_back('{name, k, v});
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_all();
    bus_b.rdy_in = 1'b1; bus_b.qry_valid = 1'b0; bus_b.upd_valid = 1'b0;
    bus_b.upd_idx = '0;  bus_b.upd_taken = 1'b0; bus_b.upd_mispred = 1'b0; bus_b.rob_clear = 1'b0;
    bus_g.rdy_in = 1'b1; bus_g.qry_valid = 1'b0; bus_g.upd_valid = 1'b0;
    bus_g.upd_idx = '0;  bus_g.upd_taken = 1'b0; bus_g.upd_mispred = 1'b0; bus_g.rob_clear = 1'b0;
  endtask

  // Power-on reset: weakly-taken table, zero history, zero miss count.
  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    idle_all();
    bus_b.qry_pc = 32'h100;
    bus_g.qry_pc = 32'h100;
    rst_in = 1'b0;
    #1 rst_in = 1'b1;
    for (int s = 0; s < 2; s++) begin
      #1;
      expect_out($sformatf("reset%0d bim taken", s), K_BT, 32'd1);
      expect_out($sformatf("reset%0d bim idx", s),   K_BI, 32'h40);
      expect_out($sformatf("reset%0d bim miss", s),  K_BM, 32'd0);
      expect_out($sformatf("reset%0d gsh taken", s), K_GT, 32'd1);
      expect_out($sformatf("reset%0d gsh idx", s),   K_GI, 32'h40);
      expect_out($sformatf("reset%0d gsh miss", s),  K_GM, 32'd0);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        checks++;
        if (obs !== e.exp) begin
          failures++;
          $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
        end
      end
      tick();
      if (s == 0) rst_in = 1'b0;
    end
  endtask

  // Counter saturation at zero; each step also checks the pre-update prediction.
  task automatic test_sat_zero();
    exp_t e;
    logic [31:0] obs;
    logic tk [5]      = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic exp_pt [6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int s = 0; s < 6; s++) begin
      idle_all();
      bus_b.qry_pc = 32'h100;
      if (s < 5) begin
        bus_b.upd_valid = 1'b1;
        bus_b.upd_idx   = 8'h40;
        bus_b.upd_taken = tk[s];
      end
      #1;
      expect_out($sformatf("sat_zero step%0d taken", s), K_BT, 32'(exp_pt[s]));
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        checks++;
        if (obs !== e.exp) begin
          failures++;
          $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
        end
      end
      tick();
    end
  endtask

  // Counter saturation at the top, back-to-back updates to entry 5 (pc 0x14).
  task automatic test_sat_top();
    exp_t e;
    logic [31:0] obs;
    logic tk [6]     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_pt [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int s = 0; s < 7; s++) begin
      idle_all();
      bus_b.qry_pc = 32'h14;
      if (s < 6) begin
        bus_b.upd_valid = 1'b1;
        bus_b.upd_idx   = 8'h05;
        bus_b.upd_taken = tk[s];
      end
      #1;
      expect_out($sformatf("sat_top step%0d taken", s), K_BT, 32'(exp_pt[s]));
      if (s == 0) expect_out("sat_top idx", K_BI, 32'h05);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        checks++;
        if (obs !== e.exp) begin
          failures++;
          $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
        end
      end
      tick();
    end
  endtask

  // Speculative history shifts in the predictions of valid queries.
  task automatic test_ghr_shift();
    exp_t e;
    logic [31:0] obs;
    logic [31:0] pc [4]      = '{32'h0, 32'h0, 32'h0, 32'h100};
    logic        qv [4]      = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_idx [4] = '{32'h00, 32'h01, 32'h03, 32'h47};
    for (int s = 0; s < 4; s++) begin
      idle_all();
      bus_g.qry_pc    = pc[s];
      bus_g.qry_valid = qv[s];
      #1;
      expect_out($sformatf("ghr step%0d idx", s),   K_GI, exp_idx[s]);
      expect_out($sformatf("ghr step%0d taken", s), K_GT, 32'd1);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        checks++;
        if (obs !== e.exp) begin
          failures++;
          $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
        end
      end
      tick();
    end
  endtask

  // Flush restore, simultaneous commit, and a not-taken prediction entering history.
  task automatic test_flush();
    exp_t e;
    logic [31:0] obs;
    logic        clr [6]     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        upd [6]     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        tk  [6]     = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0]  uidx [6]    = '{8'h20, 8'h21, 8'h21, 8'h00, 8'h00, 8'h00};
    logic        qv  [6]     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] pc  [6]     = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h8C, 32'h0};
    logic [31:0] exp_idx [6] = '{32'h07, 32'h00, 32'h01, 32'h01, 32'h20, 32'h06};
    logic        exp_pt [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int s = 0; s < 6; s++) begin
      idle_all();
      bus_g.rob_clear = clr[s];
      bus_g.upd_valid = upd[s];
      bus_g.upd_taken = tk[s];
      bus_g.upd_idx   = uidx[s];
      bus_g.qry_valid = qv[s];
      bus_g.qry_pc    = pc[s];
      #1;
      expect_out($sformatf("flush step%0d idx", s),   K_GI, exp_idx[s]);
      expect_out($sformatf("flush step%0d taken", s), K_GT, 32'(exp_pt[s]));
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        checks++;
        if (obs !== e.exp) begin
          failures++;
          $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
        end
      end
      tick();
    end
  endtask

  // rdy_in low freezes everything; miss counter counts only mispredictions.
  task automatic test_freeze_miss();
    exp_t e;
    logic [31:0] obs;
    logic        rdy [4]     = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        upd [4]     = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        tk  [4]     = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic        mis [4]     = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        exp_pt [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] exp_mc [4]  = '{32'd0, 32'd0, 32'd1, 32'd1};
    for (int s = 0; s < 4; s++) begin
      idle_all();
      bus_b.rdy_in      = rdy[s];
      bus_b.upd_valid   = upd[s];
      bus_b.upd_idx     = 8'h40;
      bus_b.upd_taken   = tk[s];
      bus_b.upd_mispred = mis[s];
      bus_b.qry_pc      = 32'h100;
      bus_g.rdy_in      = rdy[s];
      bus_g.qry_valid   = (s == 0);
      bus_g.qry_pc      = 32'h0;
      #1;
      expect_out($sformatf("freeze step%0d taken", s), K_BT, 32'(exp_pt[s]));
      expect_out($sformatf("freeze step%0d miss", s),  K_BM, exp_mc[s]);
      if (s < 2) expect_out($sformatf("freeze step%0d gsh idx", s), K_GI, 32'h06);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        checks++;
        if (obs !== e.exp) begin
          failures++;
          $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
        end
      end
      tick();
    end
    // Preload the counter at its ceiling across one mispredict edge, then mispredict again.
    force u_bim.miss_cnt_q = 32'hFFFF_FFFF;
    for (int s = 0; s < 2; s++) begin
      idle_all();
      bus_b.upd_valid   = 1'b1;
      bus_b.upd_idx     = 8'h41;
      bus_b.upd_taken   = 1'b1;
      bus_b.upd_mispred = 1'b1;
      tick();
      if (s == 0) release u_bim.miss_cnt_q;
      idle_all();
      #1;
      expect_out($sformatf("miss_sat step%0d", s), K_BM, 32'hFFFF_FFFF);
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        checks++;
        if (obs !== e.exp) begin
          failures++;
          $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
        end
      end
    end
  endtask

  // Asynchronous reset mid-operation discards in-flight training.
  task automatic test_async_reset();
    exp_t e;
    logic [31:0] obs;
    for (int s = 0; s < 4; s++) begin
      idle_all();
      bus_b.qry_pc = 32'h14;
      bus_g.qry_pc = 32'h0;
      if (s < 2) begin
        bus_b.upd_valid   = 1'b1;
        bus_b.upd_idx     = 8'h05;
        bus_b.upd_taken   = 1'b1;
        bus_b.upd_mispred = 1'b1;
      end else if (s == 3) begin
        bus_b.upd_valid = 1'b1;
        bus_b.upd_idx   = 8'h05;
        bus_b.upd_taken = 1'b0;
      end
      if (s == 1) rst_in = 1'b1;
      if (s == 2) rst_in = 1'b0;
      #1;
      // step0: counter[5]=1 before reset; step1..3: reset value 2
      expect_out($sformatf("areset step%0d taken", s), K_BT, (s == 0) ? 32'd0 : 32'd1);
      if (s > 0) begin
        expect_out($sformatf("areset step%0d miss", s),    K_BM, 32'd0);
        expect_out($sformatf("areset step%0d gsh idx", s), K_GI, 32'h0);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        obs = observe(e.kind);
        checks++;
        if (obs !== e.exp) begin
          failures++;
          $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
        end
      end
      tick();
    end
    // One not-taken commit from 2 must drop the prediction to not-taken.
    idle_all();
    bus_b.qry_pc = 32'h14;
    #1;
    expect_out("areset after train taken", K_BT, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      if (obs !== e.exp) begin
        failures++;
        $display("FAIL %s: observed 0x%0h expected 0x%0h", e.name, obs, e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sat_zero();
    test_sat_top();
    test_ghr_shift();
    test_flush();
    test_freeze_miss();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
